// File: rtl/fade_pkg.sv
// Shared types and helpers for the hue-wheel brightness sequencer.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package fade_pkg;

    typedef enum logic [2:0] {
        HIGH_A    = 3'd0,
        RAMP_DOWN = 3'd1,
        LOW_A     = 3'd2,
        LOW_B     = 3'd3,
        RAMP_UP   = 3'd4,
        HIGH_B    = 3'd5
    } phase_t;

    // Level a channel holds on entering a phase; ramps snap to these endpoints.
    function automatic int unsigned entry_level(phase_t p, int unsigned full);
        case (p)
            HIGH_A, RAMP_DOWN, HIGH_B: return full;
            default:                   return 0;
        endcase
    endfunction

    function automatic phase_t next_phase(phase_t p);
        case (p)
            HIGH_A:    return RAMP_DOWN;
            RAMP_DOWN: return LOW_A;
            LOW_A:     return LOW_B;
            LOW_B:     return RAMP_UP;
            RAMP_UP:   return HIGH_B;
            default:   return HIGH_A;
        endcase
    endfunction

endpackage

// File: rtl/fade_gen_tick_gen.sv
// Free-running prescaler producing one step_tick every INTERVAL clocks.
// Latency: step_tick is combinational from the registered count.
// Backpressure: run=0 freezes the count and suppresses step_tick.
module tick_gen #(
    parameter int unsigned INTERVAL = 10000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic step_tick
);
    import fade_pkg::*;

    localparam int unsigned CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (run) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign step_tick = run && (count == LAST);

endmodule

// File: rtl/fade_gen.sv
// Per-channel hue-wheel brightness sequencer feeding a PWM stage.
// Latency: pwm_value/phase update on the edge sampling step_tick; phase_tick follows that edge.
// Backpressure: run=0 freezes all state and forces phase_tick low.
module fade_gen #(
    parameter int unsigned PWM_INTERVAL     = 1200,
    parameter int unsigned INC_DEC_INTERVAL = 10000,
    parameter int unsigned INC_DEC_MAX      = 200,
    parameter int unsigned INC_DEC_VAL      = 6,
    parameter int unsigned START_PHASE      = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            run,
    output logic [$clog2(PWM_INTERVAL)-1:0] pwm_value,
    output logic [2:0]                      phase,
    output logic                            phase_tick
);
    import fade_pkg::*;

    localparam int unsigned W  = $clog2(PWM_INTERVAL);
    localparam int unsigned SW = (INC_DEC_MAX > 1) ? $clog2(INC_DEC_MAX) : 1;

    localparam logic [W-1:0]  FULL      = W'(PWM_INTERVAL - 1);
    localparam logic [W:0]    STEP_G    = (W+1)'(INC_DEC_VAL);
    localparam logic [W-1:0]  STEP_N    = W'(INC_DEC_VAL);
    localparam logic [SW-1:0] STEP_LAST = SW'(INC_DEC_MAX - 1);
    localparam phase_t        START     = phase_t'(3'(START_PHASE));
    localparam logic [W-1:0]  START_LVL = W'(entry_level(START, PWM_INTERVAL - 1));

    logic          step_tick;
    phase_t        phase_q, phase_d, phase_nxt;
    logic [W-1:0]  pwm_q, pwm_d;
    logic [SW-1:0] step_q, step_d;
    logic          tick_q, tick_d;
    logic [W:0]    ramp_sum;
    logic [W-1:0]  ramp_up_lvl, ramp_dn_lvl;

    tick_gen #(
        .INTERVAL (INC_DEC_INTERVAL)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step_tick (step_tick)
    );

    // Guard bit keeps the upward ramp from wrapping past FULL before the clamp.
    assign ramp_sum    = {1'b0, pwm_q} + STEP_G;
    assign ramp_up_lvl = (ramp_sum > {1'b0, FULL}) ? FULL : ramp_sum[W-1:0];
    assign ramp_dn_lvl = ({1'b0, pwm_q} < STEP_G) ? '0 : (pwm_q - STEP_N);
    assign phase_nxt   = next_phase(phase_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= START;
            pwm_q   <= START_LVL;
            step_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pwm_q   <= pwm_d;
            step_q  <= step_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        pwm_d   = pwm_q;
        step_d  = step_q;
        tick_d  = 1'b0;
        if (step_tick) begin
            if (step_q == STEP_LAST) begin
                step_d  = '0;
                phase_d = phase_nxt;
                pwm_d   = W'(entry_level(phase_nxt, PWM_INTERVAL - 1));
                tick_d  = 1'b1;
            end else begin
                step_d = step_q + 1'b1;
                case (phase_q)
                    RAMP_UP:   pwm_d = ramp_up_lvl;
                    RAMP_DOWN: pwm_d = ramp_dn_lvl;
                    default:   pwm_d = pwm_q;
                endcase
            end
        end
    end

    assign pwm_value  = pwm_q;
    assign phase      = phase_q;
    assign phase_tick = tick_q;

endmodule

// File: tb/tb_fade_gen.sv
// Bench for fade_gen: five channels (R/G/B plus two ramp-down variants) against a closed-form model.
module tb_fade_gen;

    localparam int NCH = 5;

    logic clk;
    logic reset;
    logic run;

    logic [3:0] pwm_o [NCH];
    logic [2:0] ph_o  [NCH];
    logic       tk_o  [NCH];

    // Channel 0=R(start 0), 1=G(start 4), 2=B(start 2), 3=start 1 step 3, 4=start 1 step 5
    int    starts [NCH] = '{0, 4, 2, 1, 1};
    int    vals   [NCH] = '{3, 3, 3, 3, 5};
    string names  [NCH] = '{"R", "G", "B", "D3", "D5"};

    fade_gen #(.PWM_INTERVAL(12), .INC_DEC_INTERVAL(4), .INC_DEC_MAX(4), .INC_DEC_VAL(3), .START_PHASE(0))
        u_r  (.clk(clk), .reset(reset), .run(run), .pwm_value(pwm_o[0]), .phase(ph_o[0]), .phase_tick(tk_o[0]));
    fade_gen #(.PWM_INTERVAL(12), .INC_DEC_INTERVAL(4), .INC_DEC_MAX(4), .INC_DEC_VAL(3), .START_PHASE(4))
        u_g  (.clk(clk), .reset(reset), .run(run), .pwm_value(pwm_o[1]), .phase(ph_o[1]), .phase_tick(tk_o[1]));
    fade_gen #(.PWM_INTERVAL(12), .INC_DEC_INTERVAL(4), .INC_DEC_MAX(4), .INC_DEC_VAL(3), .START_PHASE(2))
        u_b  (.clk(clk), .reset(reset), .run(run), .pwm_value(pwm_o[2]), .phase(ph_o[2]), .phase_tick(tk_o[2]));
    fade_gen #(.PWM_INTERVAL(12), .INC_DEC_INTERVAL(4), .INC_DEC_MAX(4), .INC_DEC_VAL(3), .START_PHASE(1))
        u_d3 (.clk(clk), .reset(reset), .run(run), .pwm_value(pwm_o[3]), .phase(ph_o[3]), .phase_tick(tk_o[3]));
    fade_gen #(.PWM_INTERVAL(12), .INC_DEC_INTERVAL(4), .INC_DEC_MAX(4), .INC_DEC_VAL(5), .START_PHASE(1))
        u_d5 (.clk(clk), .reset(reset), .run(run), .pwm_value(pwm_o[4]), .phase(ph_o[4]), .phase_tick(tk_o[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Count of running clock edges since the last reset; all channels share it.
    int c = 0;
    bit tk_exp = 1'b0;

    typedef struct {
        int idx;
        int ph;
        int pwm;
        bit tk;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        int n;
        bit rv;
        bit rs;
        int ph;
        int pwm;
        bit tk;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Closed form: every 4 running edges is a tick, every 4 ticks a phase.
    function automatic void predict(input int start, input int val, input int cc,
                                    output int ph, output int pwm);
        int ticks;
        int stp;
        ticks = cc / 4;
        stp   = ticks % 4;
        ph    = (start + ticks / 4) % 6;
        case (ph)
            0, 5:    pwm = 11;
            2, 3:    pwm = 0;
            4:       pwm = (val * stp > 11) ? 11 : val * stp;
            default: pwm = (11 - val * stp < 0) ? 0 : 11 - val * stp;
        endcase
    endfunction

    task automatic step(input bit rv, input bit rs);
        sb_t e;
        int ph;
        int pwm;
        @(negedge clk);
        run   = rv;
        reset = rs;
        if (rs) begin
            c      = 0;
            tk_exp = 1'b0;
        end else if (rv) begin
            c      = c + 1;
            tk_exp = (c % 16 == 0);
        end else begin
            tk_exp = 1'b0;
        end
        for (int i = 0; i < NCH; i++) begin
            predict(starts[i], vals[i], c, ph, pwm);
            e.idx = i; e.ph = ph; e.pwm = pwm; e.tk = tk_exp;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("%s phase c=%0d", names[e.idx], c), int'(ph_o[e.idx]), e.ph);
            chk($sformatf("%s pwm c=%0d", names[e.idx], c), int'(pwm_o[e.idx]), e.pwm);
            chk($sformatf("%s phase_tick c=%0d", names[e.idx], c), int'(tk_o[e.idx]), int'(e.tk));
        end
    endtask

    initial begin
        int pulses;
        int ramping;
        run   = 1'b0;
        reset = 1'b1;

        // G channel (start 4) hand-derived waypoints: reset, ramp, freeze, resume, phase advance.
        vecs[0] = '{n: 1,  rv: 1'b0, rs: 1'b1, ph: 4, pwm: 0,  tk: 1'b0};
        vecs[1] = '{n: 3,  rv: 1'b1, rs: 1'b0, ph: 4, pwm: 0,  tk: 1'b0};
        vecs[2] = '{n: 1,  rv: 1'b1, rs: 1'b0, ph: 4, pwm: 3,  tk: 1'b0};
        vecs[3] = '{n: 4,  rv: 1'b1, rs: 1'b0, ph: 4, pwm: 6,  tk: 1'b0};
        vecs[4] = '{n: 1,  rv: 1'b1, rs: 1'b0, ph: 4, pwm: 6,  tk: 1'b0};
        vecs[5] = '{n: 50, rv: 1'b0, rs: 1'b0, ph: 4, pwm: 6,  tk: 1'b0};
        vecs[6] = '{n: 2,  rv: 1'b1, rs: 1'b0, ph: 4, pwm: 6,  tk: 1'b0};
        vecs[7] = '{n: 1,  rv: 1'b1, rs: 1'b0, ph: 4, pwm: 9,  tk: 1'b0};
        vecs[8] = '{n: 4,  rv: 1'b1, rs: 1'b0, ph: 5, pwm: 11, tk: 1'b1};
        vecs[9] = '{n: 1,  rv: 1'b1, rs: 1'b0, ph: 5, pwm: 11, tk: 1'b0};

        for (int v = 0; v < 10; v++) begin
            for (int k = 0; k < vecs[v].n; k++) step(vecs[v].rv, vecs[v].rs);
            chk($sformatf("vec%0d G phase", v), int'(ph_o[1]), vecs[v].ph);
            chk($sformatf("vec%0d G pwm", v), int'(pwm_o[1]), vecs[v].pwm);
            chk($sformatf("vec%0d G phase_tick", v), int'(tk_o[1]), int'(vecs[v].tk));
        end

        // Reset in the middle of the G ramp discards the partial step.
        step(1'b1, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
        chk("mid-ramp G pwm before reset", int'(pwm_o[1]), 6);
        step(1'b1, 1'b1);
        chk("post-reset G phase", int'(ph_o[1]), 4);
        chk("post-reset G pwm", int'(pwm_o[1]), 0);
        chk("post-reset G phase_tick", int'(tk_o[1]), 0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        chk("post-reset G no early tick", int'(pwm_o[1]), 0);
        step(1'b1, 1'b0);
        chk("post-reset G first tick", int'(pwm_o[1]), 3);

        // Ramp-down with step 5 clamps at 0 instead of underflowing.
        step(1'b1, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
        chk("D5 pwm after 2 ticks", int'(pwm_o[4]), 1);
        chk("D3 pwm after 2 ticks", int'(pwm_o[3]), 5);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
        chk("D5 pwm clamped", int'(pwm_o[4]), 0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
        chk("D5 phase after ramp", int'(ph_o[4]), 2);
        chk("D3 pwm snapped", int'(pwm_o[3]), 0);

        // Full wheel on R, with exactly one of R/G/B ramping at every cycle.
        step(1'b1, 1'b1);
        pulses = 0;
        for (int k = 0; k < 96; k++) begin
            step(1'b1, 1'b0);
            ramping = 0;
            for (int i = 0; i < 3; i++) if (ph_o[i] == 3'd1 || ph_o[i] == 3'd4) ramping++;
            chk($sformatf("ramping channels c=%0d", c), ramping, 1);
            if (tk_o[0]) begin
                pulses++;
                chk($sformatf("R phase at pulse %0d", pulses), int'(ph_o[0]), pulses % 6);
            end
        end
        chk("R phase_tick pulses", pulses, 6);
        chk("R final phase", int'(ph_o[0]), 0);
        chk("R final pwm", int'(pwm_o[0]), 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
